// File: rtl/adpcm_rx.sv
// Serial ADPCM capture: resynchronises the encoder's bit stream into clk,
// deserialises one 2-5 bit code per frame and queues the codes in a small FIFO.
module adpcm_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FS_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rate,
    input  logic       enc_i,
    input  logic       enc_i_clk,
    input  logic       enc_i_fs,
    output logic [4:0] code,
    output logic [1:0] code_rate,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       sync_ok,
    output logic       rx_error,
    output logic       overflow,
    input  logic       err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FS_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_P = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TO_LIM  = CW'(FS_TIMEOUT);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Synchroniser chain, bit order {fs, bit clock, data}
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0] s_top;

    logic clk_prev_q, clk_prev_d;
    logic ev_q, ev_d;
    logic bit_q, bit_d;
    logic fs_q, fs_d;

    state_t      state_q, state_d;
    logic [4:0]  sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  cnt_inc;
    logic [2:0]  nbits;
    logic [1:0]  frame_rate_q, frame_rate_d;
    logic [CW-1:0] to_q, to_d;
    logic        frame_err;

    logic        push_q, push_d;
    logic [4:0]  push_code_q, push_code_d;
    logic [1:0]  push_rate_q, push_rate_d;

    logic [6:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        ovf_set;
    logic [6:0]  head;

    logic        rx_error_q, rx_error_d;
    logic        overflow_q, overflow_d;

    always_comb begin
        sync_d[0] = {enc_i_fs, enc_i_clk, enc_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Edge register: the event and its data/fs come from the same synchroniser stage
    assign s_top      = sync_q[SYNC_STAGES-1];
    assign clk_prev_d = s_top[1];
    assign ev_d       = s_top[1] & ~clk_prev_q;
    assign bit_d      = s_top[0];
    assign fs_d       = s_top[2];

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        frame_rate_d = frame_rate_q;
        to_d         = to_q;
        frame_err    = 1'b0;
        push_d       = 1'b0;
        push_code_d  = push_code_q;
        push_rate_d  = push_rate_q;
        nbits        = {1'b0, frame_rate_q} + 3'd2;
        cnt_inc      = cnt_q + 3'd1;

        if (state_q == S_HUNT) begin
            to_d = '0;
        end else if (to_q != TO_LIM) begin
            to_d = to_q + CW'(1);
        end

        if (ev_q && fs_q) begin
            // Any frame sync starts a fresh word; inside SHIFT it cuts a word short
            if (state_q == S_SHIFT) begin
                frame_err = 1'b1;
            end
            frame_rate_d = rate;
            sr_d         = {4'b0000, bit_q};
            cnt_d        = 3'd1;
            to_d         = '0;
            state_d      = S_SHIFT;
        end else if (state_q != S_HUNT && to_q == TO_LIM) begin
            frame_err = 1'b1;
            sr_d      = '0;
            cnt_d     = '0;
            to_d      = '0;
            state_d   = S_HUNT;
        end else if (ev_q && state_q == S_SHIFT) begin
            sr_d  = {sr_q[3:0], bit_q};
            cnt_d = cnt_inc;
            if (cnt_inc == nbits) begin
                push_d      = 1'b1;
                push_code_d = {sr_q[3:0], bit_q};
                push_rate_d = frame_rate_q;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
        end
    end

    assign code_valid = (wr_ptr_q != rd_ptr_q);
    assign full       = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign pop        = code_valid & code_ready;
    // When full, a simultaneous pop frees the slot the new word lands in
    assign wr_en      = push_q & (~full | pop);
    assign ovf_set    = push_q & full & ~pop;
    assign wr_ptr_d   = wr_ptr_q + (AW + 1)'(wr_en);
    assign rd_ptr_d   = rd_ptr_q + (AW + 1)'(pop);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign code       = code_valid ? head[4:0] : 5'd0;
    assign code_rate  = code_valid ? head[6:5] : 2'd0;

    always_comb begin
        rx_error_d = rx_error_q;
        overflow_d = overflow_q;
        if (err_clr) begin
            rx_error_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (frame_err) begin
            rx_error_d = 1'b1;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    assign sync_ok  = (state_q != S_HUNT);
    assign rx_error = rx_error_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            clk_prev_q   <= 1'b0;
            ev_q         <= 1'b0;
            bit_q        <= 1'b0;
            fs_q         <= 1'b0;
            state_q      <= S_HUNT;
            sr_q         <= '0;
            cnt_q        <= '0;
            frame_rate_q <= '0;
            to_q         <= '0;
            push_q       <= 1'b0;
            push_code_q  <= '0;
            push_rate_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rx_error_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            clk_prev_q   <= clk_prev_d;
            ev_q         <= ev_d;
            bit_q        <= bit_d;
            fs_q         <= fs_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            frame_rate_q <= frame_rate_d;
            to_q         <= to_d;
            push_q       <= push_d;
            push_code_q  <= push_code_d;
            push_rate_q  <= push_rate_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rx_error_q   <= rx_error_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: code/code_rate are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {push_rate_q, push_code_q};
        end
    end

endmodule
